logicnet_input_packer: RTL

- Producer side of the packed quantized input vector consumed by the first LUT layer's neurons.
- Accepts raw signed feature samples one per beat over a valid/ready stream with frame delimiter.
- Quantizes each sample to Q_BITS unsigned levels by arithmetic shift and clamp.
- Packs a full frame into one N_FEAT*Q_BITS vector and presents it to the layer-0 fabric through a valid/ready output register.

---
 rtl/logicnet_input_packer_if.sv | 30 +++
 rtl/logicnet_input_packer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/logicnet_input_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : logicnet_input_packer_if
// Brief    : Sample stream in, packed vector out, for the input packer.
// Revision : 1.0
// ============================================================================
interface logicnet_input_packer_if #(
  parameter int IN_W   = 8,
  parameter int N_FEAT = 3,
  parameter int Q_BITS = 2
);
  logic                     s_valid;
  logic                     s_ready;
  logic [IN_W-1:0]          s_data;
  logic                     s_last;
  logic                     m_valid;
  logic                     m_ready;
  logic [N_FEAT*Q_BITS-1:0] m_data;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface
`default_nettype wire

// File: rtl/logicnet_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : logicnet_input_packer
// Brief    : Quantizes signed samples and packs one frame into a layer-0 vector.
// Revision : 1.0
// ============================================================================
module logicnet_input_packer #(
  parameter int N_FEAT = 3,
  parameter int IN_W   = 8,
  parameter int Q_BITS = 2,
  parameter int SHIFT  = 5,
  parameter int ERR_W  = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  logicnet_input_packer_if.slave  bus,
  output logic                    frame_err,
  output logic [ERR_W-1:0]        err_cnt
);
  localparam int OUT_W = N_FEAT * Q_BITS;
  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IN_W-1:0]  C_QMAX = IN_W'((1 << Q_BITS) - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_FEAT - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_OUTPUT  = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [Q_BITS-1:0]   r_slot [N_FEAT];
  logic [OUT_W-1:0]    r_m_data;
  logic                r_m_valid;
  logic                r_s_ready;
  logic                r_frame_err;
  logic [ERR_W-1:0]    r_err_cnt;

  logic signed [IN_W-1:0] w_t;
  logic [Q_BITS-1:0]      w_q;
  logic [OUT_W-1:0]       w_packed;
  logic                   w_xfer, w_wr, w_load, w_err, w_last_slot;

  // Quantize: arithmetic shift, then clamp into 0 .. 2^Q_BITS-1.
  assign w_t = $signed(bus.s_data) >>> SHIFT;

  always_comb begin
    w_q = '0;
    if (w_t[IN_W-1]) begin
      w_q = '0;
    end else if ($unsigned(w_t) > C_QMAX) begin
      w_q = '1;
    end else begin
      w_q = w_t[Q_BITS-1:0];
    end
  end

  // The final feature bypasses the shadow slots so the vector loads on the last beat.
  for (genvar i = 0; i < N_FEAT; i++) begin : g_pack
    if (i == N_FEAT - 1) begin : g_cur
      assign w_packed[i*Q_BITS +: Q_BITS] = w_q;
    end else begin : g_shadow
      assign w_packed[i*Q_BITS +: Q_BITS] = r_slot[i];
    end
  end

  assign w_xfer      = bus.s_valid && r_s_ready;
  assign w_last_slot = (r_idx == C_LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr        = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_xfer) begin
          w_wr = 1'b1;
          if (w_last_slot) begin
            w_idx_nxt = '0;
            if (bus.s_last) begin
              w_load      = 1'b1;
              w_state_nxt = ST_OUTPUT;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          end else if (bus.s_last) begin
            w_err     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      ST_OUTPUT: begin
        if (r_m_valid && bus.m_ready) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (w_xfer && bus.s_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_COLLECT;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_COLLECT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // s_ready is registered so it stays low throughout reset and rises one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
      for (int i = 0; i < N_FEAT; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_s_ready   <= (w_state_nxt != ST_OUTPUT);
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
      if (w_wr) begin
        r_slot[r_idx] <= w_q;
      end
      if (w_load) begin
        r_m_data  <= w_packed;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && bus.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign frame_err   = r_frame_err;
  assign err_cnt     = r_err_cnt;
endmodule
`default_nettype wire
